// File: rtl/disp_pkg.sv
// Shared types and defaults for the disparity hole-filling stage.
package disp_pkg;
  localparam int DISP_DW      = 7;
  localparam int DISP_INVALID = 0;
  localparam int HOLE_CNT_W   = 16;

  typedef enum logic [1:0] {ROW_START, HOLD, EXCEED} fill_state_t;
endpackage

// File: rtl/disp_median3.sv
// Combinational 3-input median built from one compare/swap and a clamp.
module disp_median3 #(
  parameter int DW = 7
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic [DW-1:0] y
);
  logic [DW-1:0] lo, hi;

  always_comb begin
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (c < lo)      y = lo;
    else if (c > hi) y = hi;
    else             y = c;
  end
endmodule

// File: rtl/disp_hole_filler.sv
// Fills LRCC-rejected disparities with the last valid value of the row (bounded run).
// Define DISP_MEDIAN_EN to add a causal 3-tap horizontal median stage (latency 2).
module disp_hole_filler
  import disp_pkg::*;
#(
  parameter int DW      = DISP_DW,
  parameter int IMG_W   = 640,
  parameter int INVALID = DISP_INVALID,
  parameter int MAX_RUN = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_sync,
  input  logic                  i_dval,
  input  logic [DW-1:0]         i_data,
  output logic                  o_dval,
  output logic [DW-1:0]         o_data,
  output logic                  o_filled,
  output logic                  o_eol,
  output logic [HOLE_CNT_W-1:0] o_hole_cnt
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam logic [DW-1:0] INV      = DW'(INVALID);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);
`ifdef DISP_MEDIAN_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  fill_state_t           state, st_c, nxt_st;
  logic [CW-1:0]         col, col_c;
  logic [RW-1:0]         run, nxt_run;
  logic [DW-1:0]         last, nxt_last, f_data, s1_data;
  logic                  f_fill, eol_c, s1_fill, s1_eol, cnt_inc;
  logic [STAGES-1:0]     vld_pipe;
  logic [HOLE_CNT_W-1:0] hole_cnt;

  // i_sync wins: the same-cycle beat is column 0 of a fresh row.
  always_comb begin
    st_c     = i_sync ? ROW_START : state;
    col_c    = i_sync ? '0 : col;
    eol_c    = (col_c == LAST_COL);
    f_data   = i_data;
    f_fill   = 1'b0;
    nxt_st   = st_c;
    nxt_last = last;
    nxt_run  = run;
    if (i_data != INV) begin
      nxt_last = i_data;
      nxt_run  = '0;
      nxt_st   = HOLD;
    end else begin
      f_data = INV;
      if (st_c == HOLD) begin
        f_data  = last;
        f_fill  = 1'b1;
        nxt_run = run + 1'b1;
        if (nxt_run == RUN_MAX) nxt_st = EXCEED;
      end
    end
    if (eol_c) begin
      nxt_st  = ROW_START;
      nxt_run = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state    <= ROW_START;
      col      <= '0;
      run      <= '0;
      last     <= INV;
      s1_data  <= '0;
      s1_fill  <= 1'b0;
      s1_eol   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | STAGES'(i_dval);
      s1_fill  <= i_dval & f_fill;
      s1_eol   <= i_dval & eol_c;
      if (i_dval) begin
        s1_data <= f_data;
        state   <= nxt_st;
        col     <= eol_c ? '0 : col_c + 1'b1;
        run     <= nxt_run;
        last    <= nxt_last;
      end else if (i_sync) begin
        state <= ROW_START;
        col   <= '0;
        run   <= '0;
      end
    end

`ifdef DISP_MEDIAN_EN
  logic [DW-1:0] h1, h2, med, m_data;
  logic [1:0]    hcnt;
  logic          m_fill, m_eol;

  disp_median3 #(.DW(DW)) u_med (.a(h2), .b(h1), .c(s1_data), .y(med));

  // History holds the filled stream of the current row only.
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      h1     <= INV;
      h2     <= INV;
      hcnt   <= '0;
      m_data <= '0;
      m_fill <= 1'b0;
      m_eol  <= 1'b0;
    end else begin
      m_fill <= vld_pipe[0] & s1_fill;
      m_eol  <= vld_pipe[0] & s1_eol;
      if (vld_pipe[0]) begin
        m_data <= (hcnt == 2'd2) ? med : s1_data;
        h2     <= h1;
        h1     <= s1_data;
        hcnt   <= s1_eol ? 2'd0 : ((hcnt == 2'd2) ? 2'd2 : hcnt + 2'd1);
      end
      if (i_sync) hcnt <= '0;
    end

  assign o_dval   = vld_pipe[1];
  assign o_data   = m_data;
  assign o_filled = m_fill;
  assign o_eol    = m_eol;
  assign cnt_inc  = vld_pipe[0] & s1_fill;
`else
  assign o_dval   = vld_pipe[0];
  assign o_data   = s1_data;
  assign o_filled = s1_fill;
  assign o_eol    = s1_eol;
  assign cnt_inc  = i_dval & f_fill;
`endif

  // Counts as the filled beat lands in the output register.
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn)                    hole_cnt <= '0;
    else if (i_sync)                hole_cnt <= '0;
    else if (cnt_inc && ~&hole_cnt) hole_cnt <= hole_cnt + 1'b1;

  assign o_hole_cnt = hole_cnt;
endmodule

// File: tb/tb_disp_hole_filler.sv
// Scoreboard bench for disp_hole_filler; expectations follow DISP_MEDIAN_EN if defined.
module tb_disp_hole_filler;
  import disp_pkg::*;
  localparam int DW = 7, IMG_W = 24, MAX_RUN = 15;
  localparam logic [DW-1:0] INV = '0;
`ifdef DISP_MEDIAN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          fill;
    logic          eol;
    int            cyc;
  } exp_t;

  logic i_clk = 1'b0, i_rstn = 1'b0, i_sync = 1'b0, i_dval = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic o_dval, o_filled, o_eol;
  logic [DW-1:0] o_data;
  logic [HOLE_CNT_W-1:0] o_hole_cnt;

  exp_t q[$];
  int n_chk = 0, n_pass = 0, cyc = 0, bcol = 0, exp_holes = 0;
`ifdef DISP_MEDIAN_EN
  int ecnt = 0;
  logic [DW-1:0] eh1 = '0, eh2 = '0;
`endif

  disp_hole_filler #(.DW(DW), .IMG_W(IMG_W), .INVALID(0), .MAX_RUN(MAX_RUN)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_sync(i_sync), .i_dval(i_dval), .i_data(i_data),
    .o_dval(o_dval), .o_data(o_data), .o_filled(o_filled), .o_eol(o_eol),
    .o_hole_cnt(o_hole_cnt)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

`ifdef DISP_MEDIAN_EN
  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, b, c);
    if ((a <= b && b <= c) || (c <= b && b <= a)) return b;
    if ((b <= a && a <= c) || (c <= a && a <= b)) return a;
    return c;
  endfunction
`endif

  task automatic push(input logic [DW-1:0] fv, input logic ff);
    exp_t e;
    logic eol;
    eol    = (bcol == IMG_W - 1);
    e.data = fv;
`ifdef DISP_MEDIAN_EN
    if (ecnt == 2) e.data = med3(eh2, eh1, fv);
    eh2  = eh1;
    eh1  = fv;
    ecnt = eol ? 0 : ((ecnt == 2) ? 2 : ecnt + 1);
`endif
    e.fill = ff;
    e.eol  = eol;
    e.cyc  = cyc + LAT;
    q.push_back(e);
    if (ff) exp_holes++;
    bcol = eol ? 0 : bcol + 1;
  endtask

  task automatic model_restart();
    bcol      = 0;
    exp_holes = 0;
`ifdef DISP_MEDIAN_EN
    ecnt = 0;
`endif
  endtask

  // d = driven pixel, ed/ef = expected filled value and filled flag
  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] ed, input logic ef,
                      input int gap = 0, input logic s = 1'b0);
    if (s) model_restart();
    push(ed, ef);
    i_dval = 1'b1;
    i_data = d;
    i_sync = s;
    @(posedge i_clk); #1;
    i_dval = 1'b0;
    i_sync = 1'b0;
    repeat (gap) begin @(posedge i_clk); #1; end
  endtask

  task automatic pad(input logic [DW-1:0] v);
    while (bcol != 0) send(v, v, 1'b0);
  endtask

  task automatic drain(input string tag);
    repeat (LAT + 3) begin @(posedge i_clk); #1; end
    chk({tag, "_sb_empty"}, q.size(), 0);
    chk({tag, "_holes"}, o_hole_cnt, exp_holes);
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rstn && o_dval) begin
      if (q.size() == 0) chk("extra_beat", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", o_data, e.data);
        chk("filled", o_filled, e.fill);
        chk("eol", o_eol, e.eol);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_dval", o_dval, 0);
    chk("rst_data", o_data, 0);
    chk("rst_filled", o_filled, 0);
    chk("rst_eol", o_eol, 0);
    chk("rst_holes", o_hole_cnt, 0);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // short holes filled with the last valid pixel
    send(5, 5, 0); send(INV, 5, 1); send(INV, 5, 1); send(9, 9, 0); pad(9);
    drain("t1");

    // leading invalids have nothing to fill from
    send(INV, INV, 0); send(INV, INV, 0); send(4, 4, 0); pad(4);
    drain("t2");

    // run limit: 15 filled, the rest pass as invalid
    send(3, 3, 0);
    repeat (MAX_RUN) send(INV, 3, 1);
    repeat (5) send(INV, INV, 0);
    send(7, 7, 0); pad(7);
    drain("t3");

    // no fill across the row boundary
    repeat (IMG_W - 1) send(1, 1, 0);
    send(6, 6, 0);
    send(INV, INV, 0); send(5, 5, 0); send(INV, 5, 1);
    drain("t4");
    // sync with a beat in HOLD state: restart at col 0, counter cleared
    send(INV, INV, 0, 0, 1'b1);
    chk("sync_holes", o_hole_cnt, 0);
    send(INV, INV, 0); send(4, 4, 0); send(INV, 4, 1); pad(4);
    drain("t4s");

    // median pattern (identity when the median stage is absent)
    send(2, 2, 0); send(9, 9, 0); send(3, 3, 0); send(3, 3, 0); send(8, 8, 0); pad(8);
    drain("t5");

    // gapped input behaves like the gapless stream
    send(5, 5, 0, 3); send(INV, 5, 1, 3); send(INV, 5, 1, 3); send(9, 9, 0, 3); send(9, 9, 0, 3);
    drain("t6g");

    // async reset mid-row
    #2 i_rstn = 1'b0;
    #1;
    chk("mid_rst_dval", o_dval, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_holes", o_hole_cnt, 0);
    model_restart();
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    send(7, 7, 0); send(INV, 7, 1); pad(7);
    drain("t6r");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
